// File: rtl/boot_loader_if.sv
// Host-side boot bus: load control, word stream, Icache write port and core status.
// The slave side is the boot sequencer; the master side is the host or test driver.
interface boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  boot_start;
  logic [ADDR_WIDTH:0]   boot_len;
  logic                  abort;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  core_halt;
  logic                  core_rst;
  logic                  run;
  logic                  busy;
  logic                  error;

  modport slave (
    input  boot_start, boot_len, abort, s_valid, s_data, core_halt,
    output s_ready, mem_wen, mem_addr, mem_wdata, core_rst, run, busy, error
  );

  modport master (
    output boot_start, boot_len, abort, s_valid, s_data, core_halt,
    input  s_ready, mem_wen, mem_addr, mem_wdata, core_rst, run, busy, error
  );
endinterface

// File: rtl/boot_loader.sv
// Boot sequencer: writes a length-prefixed word stream into the Icache, verifies a trailing
// additive checksum, then holds the core in reset for RELEASE_DLY cycles before letting it run.
module boot_loader #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RELEASE_DLY = 4
) (
  input logic          clk,
  input logic          rst,
  boot_loader_if.slave bus
);
  localparam int unsigned LenW = ADDR_WIDTH + 1;
  localparam int unsigned DlyW = $clog2(RELEASE_DLY + 1);
  localparam logic [LenW-1:0] MaxLen  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [DlyW-1:0] DlyInit = DlyW'(RELEASE_DLY);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StRelease,
    StRun,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [LenW-1:0]       len_q, len_d;
  logic [LenW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DlyW-1:0]       dly_q, dly_d;
  logic                  s_ready_q, s_ready_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  core_rst_q, core_rst_d;
  logic                  run_q, run_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic                  accept;

  assign accept = bus.s_valid & s_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    dly_d       = dly_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle, StError: begin
        if ((state_q == StError) && bus.abort) begin
          state_d = StIdle;
        end else if (bus.boot_start) begin
          len_d      = bus.boot_len;
          cnt_d      = '0;
          sum_d      = '0;
          mem_addr_d = '0;
          // Oversized images are rejected up front so the address never wraps.
          if (bus.boot_len > MaxLen) begin
            state_d = StError;
          end else if (bus.boot_len == '0) begin
            state_d = StCheck;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StLoad: begin
        // An abort coinciding with a handshake swallows the word without writing or summing.
        if (bus.abort) begin
          state_d = StIdle;
        end else if (accept) begin
          mem_wen_d   = 1'b1;
          mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
          mem_wdata_d = bus.s_data;
          sum_d       = sum_q + bus.s_data;
          cnt_d       = cnt_q + LenW'(1);
          if (cnt_q == (len_q - LenW'(1))) begin
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (accept) begin
          dly_d   = DlyInit;
          state_d = (bus.s_data == sum_q) ? StRelease : StError;
        end
      end

      StRelease: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          dly_d = dly_q - DlyW'(1);
          if (dly_q == DlyW'(1)) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (bus.core_halt) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies of the next-state decode.
    s_ready_d  = (state_d == StLoad) || (state_d == StCheck);
    busy_d     = s_ready_d || (state_d == StRelease);
    run_d      = (state_d == StRun);
    core_rst_d = ~run_d;
    error_d    = (state_d == StError);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      dly_q       <= '0;
      s_ready_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      dly_q       <= dly_d;
      s_ready_q   <= s_ready_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.core_rst  = core_rst_q;
  assign bus.run       = run_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;
endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: table of load scenarios plus hand-written abort/halt/reset sequences.
// Icache writes are checked against a scoreboard queue filled as words are handed over.
module tb_boot_loader;
  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned DLY = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  boot_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RELEASE_DLY(DLY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit gaps;
    bit bad;
    bit exp_run;
    bit exp_err;
  } vec_t;

  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   n_writes = 0;
  int   wcyc[$];
  wr_t  exp_q[$];
  wr_t  got_e;
  logic [DW-1:0] happy [4];
  vec_t vecs [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Write monitor: every Icache write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && bus.mem_wen === 1'b1) begin
      n_writes++;
      wcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        got_e = exp_q.pop_front();
        check("write_addr", 64'(bus.mem_addr), 64'(got_e.addr));
        check("write_data", 64'(bus.mem_wdata), 64'(got_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW:0] len, output int c0);
    bus.boot_start = 1'b1;
    bus.boot_len   = len;
    c0             = cyc;
    tick();
    bus.boot_start = 1'b0;
  endtask

  // Hands over w[] in order; words below nimg are image words expected in the Icache.
  task automatic stream(input logic [DW-1:0] w[$], input int nimg, input bit gaps,
                        input int abort_idx);
    int  t;
    wr_t e;
    for (int i = 0; i < w.size(); i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = w[i];
      t = 0;
      @(negedge clk);
      while (bus.s_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (bus.s_ready !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stream_stall: word %0d s_ready=%b, expected 1", i, bus.s_ready);
        bus.s_valid = 1'b0;
        tick();
        return;
      end
      bus.abort = (i == abort_idx);
      if (i < nimg && i != abort_idx) begin
        e.addr = AW'(i);
        e.data = w[i];
        exp_q.push_back(e);
      end
      tick();
      bus.s_valid = 1'b0;
      bus.abort   = 1'b0;
      if (i == abort_idx) return;
      if (gaps) tick();
    end
  endtask

  task automatic go_idle();
    if (bus.run === 1'b1) begin
      bus.core_halt = 1'b1;
      tick();
      bus.core_halt = 1'b0;
    end else if (bus.error === 1'b1 || bus.busy === 1'b1) begin
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
    end
    tick();
  endtask

  // Waits for run or error; returns the cycle of the first sample showing either.
  task automatic wait_done(output int done_cyc);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.run !== 1'b1 && bus.error !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    done_cyc = cyc;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"},   64'(bus.s_ready),   64'(0));
    check({tag, "_mem_wen"},   64'(bus.mem_wen),   64'(0));
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'(0));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({tag, "_core_rst"},  64'(bus.core_rst),  64'(1));
    check({tag, "_run"},       64'(bus.run),       64'(0));
    check({tag, "_busy"},      64'(bus.busy),      64'(0));
    check({tag, "_error"},     64'(bus.error),     64'(0));
  endtask

  initial begin
    logic [DW-1:0] w[$];
    logic [DW-1:0] sum;
    int c0, w0, nw0, dc;

    // Model sum of these four words is 0x00308228.
    happy[0] = 32'h0000_0013;
    happy[1] = 32'h0010_0093;
    happy[2] = 32'h0020_8113;
    happy[3] = 32'h0000_006F;

    //          len gaps bad run err
    vecs[0] = '{4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3, 1'b1, 1'b1, 1'b0, 1'b1};

    bus.boot_start = 1'b0;
    bus.boot_len   = '0;
    bus.abort      = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.core_halt  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      go_idle();
      w   = {};
      sum = '0;
      for (int i = 0; i < vecs[v].len; i++) begin
        w.push_back((vecs[v].len == 4) ? happy[i] : $urandom);
        sum = sum + w[i];
      end
      w.push_back(vecs[v].bad ? sum + 1 : sum);
      nw0 = n_writes;
      w0  = wcyc.size();
      start((AW + 1)'(vecs[v].len), c0);
      stream(w, vecs[v].len, vecs[v].gaps, -1);
      wait_done(dc);
      check($sformatf("v%0d_run", v),      64'(bus.run),      64'(vecs[v].exp_run));
      check($sformatf("v%0d_error", v),    64'(bus.error),    64'(vecs[v].exp_err));
      check($sformatf("v%0d_core_rst", v), 64'(bus.core_rst), 64'(!vecs[v].exp_run));
      check($sformatf("v%0d_writes", v),   64'(n_writes - nw0), 64'(vecs[v].len));
      check($sformatf("v%0d_sb_empty", v), 64'(exp_q.size()), 64'(0));
      if (vecs[v].exp_run && !vecs[v].gaps)
        check($sformatf("v%0d_run_cycle", v), 64'(dc - c0), 64'(vecs[v].len + 2 + DLY));
      if (vecs[v].exp_err && !vecs[v].gaps)
        check($sformatf("v%0d_err_cycle", v), 64'(dc - c0), 64'(vecs[v].len + 2));
      if (!vecs[v].gaps && vecs[v].len > 0) begin
        check($sformatf("v%0d_first_wr_cyc", v), 64'(wcyc[w0] - c0), 64'(2));
        check($sformatf("v%0d_last_wr_cyc", v),
              64'(wcyc[w0 + vecs[v].len - 1] - c0), 64'(vecs[v].len + 1));
      end
      @(posedge clk);
      #1;
    end

    // Retry from ERROR clears the sticky error.
    start(9'd4, c0);
    @(negedge clk);
    check("retry_error", 64'(bus.error), 64'(0));
    check("retry_busy",  64'(bus.busy),  64'(1));
    @(posedge clk);
    #1;
    go_idle();

    // Oversized length goes straight to ERROR with no writes.
    nw0 = n_writes;
    start(9'd257, c0);
    @(negedge clk);
    check("len257_error", 64'(bus.error), 64'(1));
    check("len257_busy",  64'(bus.busy),  64'(0));
    @(posedge clk);
    #1;
    repeat (3) tick();
    check("len257_writes", 64'(n_writes - nw0), 64'(0));
    go_idle();
    check("abort_from_error", 64'(bus.error), 64'(0));

    // Full-size image covers every address exactly once.
    w   = {};
    sum = '0;
    for (int i = 0; i < 256; i++) begin
      w.push_back($urandom);
      sum = sum + w[i];
    end
    w.push_back(sum);
    nw0 = n_writes;
    start(9'd256, c0);
    stream(w, 256, 1'b0, -1);
    wait_done(dc);
    check("len256_run",       64'(bus.run),          64'(1));
    check("len256_writes",    64'(n_writes - nw0),   64'(256));
    check("len256_sb_empty",  64'(exp_q.size()),     64'(0));
    check("len256_run_cycle", 64'(dc - c0),          64'(256 + 2 + DLY));
    @(posedge clk);
    #1;

    // boot_start is ignored while running.
    bus.boot_start = 1'b1;
    bus.boot_len   = 9'd4;
    tick();
    bus.boot_start = 1'b0;
    @(negedge clk);
    check("run_ignore_start_run",  64'(bus.run),     64'(1));
    check("run_ignore_start_busy", 64'(bus.busy),    64'(0));
    check("run_ignore_start_rdy",  64'(bus.s_ready), 64'(0));
    @(posedge clk);
    #1;

    // core_halt returns the core to reset on the next cycle.
    bus.core_halt = 1'b1;
    tick();
    bus.core_halt = 1'b0;
    @(negedge clk);
    check("halt_core_rst", 64'(bus.core_rst), 64'(1));
    check("halt_run",      64'(bus.run),      64'(0));
    @(posedge clk);
    #1;
    tick();

    // Abort with the third accepted word: only two writes land.
    w = {};
    for (int i = 0; i < 4; i++) w.push_back(happy[i]);
    w.push_back(32'h0030_8228);
    nw0 = n_writes;
    start(9'd4, c0);
    stream(w, 4, 1'b0, 2);
    @(negedge clk);
    check("abort_busy",     64'(bus.busy),     64'(0));
    check("abort_core_rst", 64'(bus.core_rst), 64'(1));
    check("abort_s_ready",  64'(bus.s_ready),  64'(0));
    check("abort_writes",   64'(n_writes - nw0), 64'(2));
    check("abort_sb_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
    tick();

    // Synchronous reset in the middle of a load.
    w = {};
    w.push_back(happy[0]);
    w.push_back(happy[1]);
    start(9'd4, c0);
    stream(w, 4, 1'b0, -1);
    tick();
    @(negedge clk);
    check("mid_load_busy",     64'(bus.busy),     64'(1));
    check("mid_load_sb_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
